mem_slot_arbiter: RTL

Shares the single-port system memory between the 6502C CPU and a DMA requester, such as display-list or playfield fetch, by stealing whole memory slots. It raises the CPU halt line, waits until the CPU is stalled on a read cycle, and then owns the address bus for a burst of consecutive read slots. After the burst it returns the bus to the CPU. It sits between `top_6502C`'s external bus (`extABH`/`extABL`, `RW`) and the memory address/write-enable port.

---
 rtl/arb_pkg.sv | 19 +
 rtl/dma_addr_gen.sv | 64 ++++++
 rtl/mem_slot_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the memory slot arbiter.
//   arb_state_e    : arbiter FSM encoding
//   MAX_CPU_WRITES : longest run of unhaltable 6502 write cycles (JSR/BRK push)
//   BUS_CPU/BUS_DMA: busOwner encoding
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_RD = 2'd1,
      DMA     = 2'd2,
      DRAIN   = 2'd3
   } arb_state_e;

   localparam int   MAX_CPU_WRITES = 3;

   localparam logic BUS_CPU = 1'b0;
   localparam logic BUS_DMA = 1'b1;

endpackage

// File: rtl/dma_addr_gen.sv
// Burst address generator for the memory slot arbiter.
// Holds the burst base address, length and byte index; produces the
// wrapping 16-bit address base+idx and flags the final byte of the burst.
//   fastClk, RES_L : clock, async active-low reset
//   load           : latch base_in/len_in and clear the index
//   base_in/len_in : burst start address and length
//   adv            : step to the next byte (held at the last byte)
//   addr           : base+idx, mod 2^16
//   last           : the current byte is the final one of the burst
//   idx_nz         : index is past the first byte
module dma_addr_gen
   import arb_pkg::*;
#(
   parameter int BURST_W = 4
) (
   input  logic               fastClk,
   input  logic               RES_L,
   input  logic               load,
   input  logic [15:0]        base_in,
   input  logic [BURST_W-1:0] len_in,
   input  logic               adv,
   output logic [15:0]        addr,
   output logic               last,
   output logic               idx_nz
);

   logic [15:0]        base_q, base_d;
   logic [BURST_W-1:0] len_q, len_d;
   logic [BURST_W-1:0] idx_q, idx_d;
   logic [BURST_W:0]   idx_inc;

   // idx never advances past len-1, so the DRAIN slot keeps presenting
   // the address of the final byte.
   assign idx_inc = {1'b0, idx_q} + (BURST_W+1)'(1);
   assign last    = (idx_inc == {1'b0, len_q});
   assign addr    = base_q + 16'(idx_q);
   assign idx_nz  = |idx_q;

   always_comb begin
      base_d = base_q;
      len_d  = len_q;
      idx_d  = idx_q;
      if (load) begin
         base_d = base_in;
         len_d  = len_in;
         idx_d  = '0;
      end else if (adv && !last) begin
         idx_d = idx_inc[BURST_W-1:0];
      end
   end

   always_ff @(posedge fastClk or negedge RES_L) begin
      if (!RES_L) begin
         base_q <= '0;
         len_q  <= '0;
         idx_q  <= '0;
      end else begin
         base_q <= base_d;
         len_q  <= len_d;
         idx_q  <= idx_d;
      end
   end

endmodule

// File: rtl/mem_slot_arbiter.sv
// Memory slot arbiter between the 6502C external bus and a DMA client.
// Halts the CPU, waits for it to stall on a read, then steals whole memory
// slots for a burst of consecutive reads before handing the bus back.
//   fastClk, RES_L   : clock, async active-low reset
//   slotTick         : one-cycle pulse at each memory slot boundary
//   cpuAddr, cpuRW   : CPU external bus (RW=1 is a read)
//   memDout          : synchronous memory read data
//   dmaReq/Addr/Len  : DMA burst request, address and length
//   memAddr, memWe   : memory address / write enable (muxed on busOwner)
//   cpuHalt          : CPU HALT
//   busOwner         : 0 CPU, 1 DMA
//   dmaAck           : burst accepted pulse
//   dmaData/dmaValid : captured DMA byte and its strobe
//   dmaDone          : strobe on the final byte of a burst
//   arbErr           : sticky write-run watchdog error
// Optional: define ARB_WATCHDOG_EN to flag a CPU that keeps writing for more
// than MAX_CPU_WRITES slots while a burst waits; otherwise arbErr is 0.
//
// state   | meaning
// IDLE    | CPU owns the bus, guard counts down, waits for a request
// WAIT_RD | CPU halted but still on the bus until it sits on a read
// DMA     | DMA owns the bus, one burst byte address per slot
// DRAIN   | last address held one more slot to collect the final byte
module mem_slot_arbiter
   import arb_pkg::*;
#(
   parameter int BURST_W       = 4,
   parameter int CPU_MIN_SLOTS = 1
) (
   input  logic               fastClk,
   input  logic               RES_L,
   input  logic               slotTick,
   input  logic [15:0]        cpuAddr,
   input  logic               cpuRW,
   input  logic [7:0]         memDout,
   input  logic               dmaReq,
   input  logic [15:0]        dmaAddr,
   input  logic [BURST_W-1:0] dmaLen,
   output logic [15:0]        memAddr,
   output logic               memWe,
   output logic               cpuHalt,
   output logic               busOwner,
   output logic               dmaAck,
   output logic [7:0]         dmaData,
   output logic               dmaValid,
   output logic               dmaDone,
   output logic               arbErr
);

   localparam int GUARD_W = (CPU_MIN_SLOTS > 1) ? $clog2(CPU_MIN_SLOTS + 1) : 1;

   arb_state_e         state_q, state_d;
   logic               halt_q, halt_d;
   logic               owner_q, owner_d;
   logic               ack_q, ack_d;
   logic               valid_q, valid_d;
   logic               done_q, done_d;
   logic [7:0]         data_q, data_d;
   logic [GUARD_W-1:0] guard_q, guard_d, guard_dec;

   logic               gen_load;
   logic               gen_adv;
   logic [15:0]        gen_addr;
   logic               gen_last;
   logic               gen_idx_nz;

   dma_addr_gen #(
      .BURST_W (BURST_W)
   ) u_addr_gen (
      .fastClk (fastClk),
      .RES_L   (RES_L),
      .load    (gen_load),
      .base_in (dmaAddr),
      .len_in  (dmaLen),
      .adv     (gen_adv),
      .addr    (gen_addr),
      .last    (gen_last),
      .idx_nz  (gen_idx_nz)
   );

   // The slot ending at an IDLE tick was CPU-owned, so it already counts
   // toward the guard; accept is judged on the decremented value.
   assign guard_dec = (guard_q == '0) ? '0 : guard_q - GUARD_W'(1);

   always_comb begin
      state_d  = state_q;
      halt_d   = halt_q;
      owner_d  = owner_q;
      ack_d    = 1'b0;
      valid_d  = 1'b0;
      done_d   = 1'b0;
      data_d   = data_q;
      guard_d  = guard_q;
      gen_load = 1'b0;
      gen_adv  = 1'b0;
      if (slotTick) begin
         case (state_q)
            IDLE: begin
               guard_d = guard_dec;
               if (dmaReq && (guard_dec == '0) && (dmaLen != '0)) begin
                  gen_load = 1'b1;
                  ack_d    = 1'b1;
                  halt_d   = 1'b1;
                  state_d  = WAIT_RD;
               end
            end
            WAIT_RD: begin
               // Write cycles cannot be halted; only take the bus on a read.
               if (cpuRW) begin
                  owner_d = BUS_DMA;
                  state_d = DMA;
               end
            end
            DMA: begin
               gen_adv = 1'b1;
               // Synchronous memory: data for idx-1 arrives on this tick.
               if (gen_idx_nz) begin
                  data_d  = memDout;
                  valid_d = 1'b1;
               end
               if (gen_last) begin
                  state_d = DRAIN;
               end
            end
            DRAIN: begin
               data_d  = memDout;
               valid_d = 1'b1;
               done_d  = 1'b1;
               halt_d  = 1'b0;
               owner_d = BUS_CPU;
               guard_d = GUARD_W'(CPU_MIN_SLOTS);
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge fastClk or negedge RES_L) begin
      if (!RES_L) begin
         state_q <= IDLE;
         halt_q  <= 1'b0;
         owner_q <= BUS_CPU;
         ack_q   <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         data_q  <= '0;
         guard_q <= '0;
      end else begin
         state_q <= state_d;
         halt_q  <= halt_d;
         owner_q <= owner_d;
         ack_q   <= ack_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         data_q  <= data_d;
         guard_q <= guard_d;
      end
   end

`ifdef ARB_WATCHDOG_EN
   logic [1:0] wd_cnt_q, wd_cnt_d;
   logic       err_q, err_d;

   always_comb begin
      wd_cnt_d = wd_cnt_q;
      err_d    = err_q;
      if (slotTick) begin
         if (state_q == WAIT_RD) begin
            if (cpuRW) begin
               wd_cnt_d = '0;
            end else if (wd_cnt_q == 2'(MAX_CPU_WRITES)) begin
               err_d = 1'b1;
            end else begin
               wd_cnt_d = wd_cnt_q + 2'd1;
            end
         end else begin
            wd_cnt_d = '0;
         end
      end
   end

   always_ff @(posedge fastClk or negedge RES_L) begin
      if (!RES_L) begin
         wd_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
         err_q    <= err_d;
      end
   end

   assign arbErr = err_q;
`else
   assign arbErr = 1'b0;
`endif

   assign memAddr  = (owner_q == BUS_DMA) ? gen_addr : cpuAddr;
   assign memWe    = (owner_q == BUS_DMA) ? 1'b0 : ~cpuRW;
   assign cpuHalt  = halt_q;
   assign busOwner = owner_q;
   assign dmaAck   = ack_q;
   assign dmaData  = data_q;
   assign dmaValid = valid_q;
   assign dmaDone  = done_q;

endmodule
